mem_wb: RTL and testbench
=========================

# mem_wb

Memory/write-back stage of the multi-cycle RV32I core, directly downstream of the execute stage. Takes one completed execute result per handshake and retires it: a register write-back, a PC redirect with optional link write, or a byte-serial load/store through an arbitrated 8-bit RAM port. Drives the register-file write port and PC write port, then returns a one-cycle `ex_mem_done` pulse so execute can accept the next instruction.

## Interface
- `LOG_REG_CNT`, 5, register index width
- `REG_LEN`, 32, register/data width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global enable; 0 freezes all state (RAM wrapper freezes with it, `ram_din` stable)
- `ex_done`  in  1  execute result valid this cycle; all `ex_*` fields stable until `ex_mem_done`
- `write_pc`  in  1  redirect request
- `write_pc_val`  in  32  new PC
- `jmp_rd`  in  LOG_REG_CNT  link register (0 = none)
- `jmp_rd_val`  in  32  link value
- `write_reg_op`  in  2  0 IDLE, 1 WB, 2 LOAD, 3 STORE
- `write_reg_id`  in  LOG_REG_CNT  destination register
- `write_reg_val`  in  REG_LEN  WB result / store data
- `mem_addr`  in  32  effective address
- `mem_type`  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- `ex_mem_done`  out  1  one-cycle retire pulse
- `rf_we` / `rf_waddr` / `rf_wdata`  out  1 / LOG_REG_CNT / REG_LEN  register-file write port
- `pc_we` / `pc_wdata`  out  1 / 32  PC write port
- `mem_req`  out  1  RAM port request to arbiter
- `mem_gnt`  in  1  arbiter grant, level
- `ram_a`  out  32  byte address
- `ram_dout`  out  8  write byte
- `ram_wr`  out  1  1 write, 0 read
- `ram_din`  in  8  read byte, valid one cycle after its address

## Operation
- States: IDLE, REQ, XFER, LAST, DONE. All outputs registered.
- IDLE, `ex_done`=1: `write_pc`=1 → DONE with `pc_we`, plus link write if `jmp_rd`≠0 (`write_reg_op` ignored). Else WB/IDLE → DONE (WB writes `write_reg_val` to `write_reg_id`). LOAD/STORE → REQ; latch address, data, type; n = 1/2/4 bytes by type.
- REQ: `mem_req`=1; on `mem_gnt` → XFER, k=0.
- XFER cycle k: `ram_a`=addr+k (32-bit wrap), store: `ram_wr`=1, `ram_dout`=data[8k+7:8k]; load: `ram_wr`=0, byte k−1 captured from `ram_din` when k≥1. After k=n−1: store → DONE, load → LAST.
- LAST: capture byte n−1, `ram_wr`=0 → DONE.
- DONE: `ex_mem_done`=1 for one cycle, `mem_req`=0; load writes assembled little-endian value, LB/LH sign-extend, LBU/LHU zero-extend → IDLE.
- Writes to x0 suppressed (`rf_we`=0); loads to x0 still perform reads. Misaligned addresses allowed.
- `mem_req` held from REQ through LAST; grant assumed stable once given.

## Timing
- Reset values: all outputs 0, state IDLE; reset mid-transfer drops `mem_req` immediately, already-written bytes stay.
- C0 = cycle `ex_done` sampled high. WB/jump/IDLE-op: done in C1. Store, grant already high: REQ C1, bytes C2..C(1+n), done C(2+n) (SW = C6). Load: done C(3+n) (LB = C4, LW = C7). Each cycle grant is withheld adds one.
- `ex_done` ignored outside IDLE; next instruction accepted earliest cycle after DONE.
- `rdy`=0: no state, counter or output changes.

## Test plan
- ADDI result: `ex_done`, WB, rd=5, val=0x0000002A → C1: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x2A, `ex_mem_done`=1; C2 all 0.
- JAL: `write_pc`=1, pc 0x1000, `jmp_rd`=1, link 0x0104 → C1: `pc_we`, `pc_wdata`=0x1000, `rf_we`, x1=0x0104; repeat `jmp_rd`=0 → `rf_we`=0.
- LW at 0x100, RAM bytes 78 56 34 12, grant delayed 3 cycles → `ram_a` 0x100..0x103, x7=0x12345678, done at C10.
- LH at 0x200 bytes 0x00,0x80 → 0xFFFF8000; LHU → 0x00008000; LB to x0 → reads happen, `rf_we`=0.
- SB 0xDEADBEEF at 0x3 → single `ram_wr` cycle, `ram_a`=0x3, `ram_dout`=0xEF, done C3; SH at 0xFFFFFFFF → addresses 0xFFFFFFFF, 0x0.
- `rst` during XFER of LW → next cycle `mem_req`=0, no `rf_we`, no `ex_mem_done`, state IDLE.

Source files
------------

// File: rtl/mem_wb_if.sv
// mem_wb_if: bundle of the signals between the execute stage, the mem_wb stage, the
// register-file/PC write ports and the arbitrated byte-wide RAM port.
//   slave  : the mem_wb stage (consumes the execute result, drives the write ports and RAM port)
//   master : its environment (execute stage, register file, PC, arbiter and RAM)
interface mem_wb_if #(
    parameter int unsigned LOG_REG_CNT = 5,
    parameter int unsigned REG_LEN     = 32
);
    // Execute-stage result, stable from ex_done until ex_mem_done
    logic                   ex_done;
    logic                   write_pc;
    logic [31:0]            write_pc_val;
    logic [LOG_REG_CNT-1:0] jmp_rd;
    logic [31:0]            jmp_rd_val;
    logic [1:0]             write_reg_op;
    logic [LOG_REG_CNT-1:0] write_reg_id;
    logic [REG_LEN-1:0]     write_reg_val;
    logic [31:0]            mem_addr;
    logic [2:0]             mem_type;
    logic                   ex_mem_done;
    // Register-file and PC write ports
    logic                   rf_we;
    logic [LOG_REG_CNT-1:0] rf_waddr;
    logic [REG_LEN-1:0]     rf_wdata;
    logic                   pc_we;
    logic [31:0]            pc_wdata;
    // Arbitrated RAM port
    logic                   mem_req;
    logic                   mem_gnt;
    logic [31:0]            ram_a;
    logic [7:0]             ram_dout;
    logic                   ram_wr;
    logic [7:0]             ram_din;

    modport master (
        output ex_done, write_pc, write_pc_val, jmp_rd, jmp_rd_val, write_reg_op,
               write_reg_id, write_reg_val, mem_addr, mem_type, mem_gnt, ram_din,
        input  ex_mem_done, rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, mem_req,
               ram_a, ram_dout, ram_wr
    );

    modport slave (
        input  ex_done, write_pc, write_pc_val, jmp_rd, jmp_rd_val, write_reg_op,
               write_reg_id, write_reg_val, mem_addr, mem_type, mem_gnt, ram_din,
        output ex_mem_done, rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, mem_req,
               ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: memory/write-back stage of the multi-cycle RV32I core.
// Retires one execute result per handshake: a register write-back, a PC redirect with optional
// link write, or a byte-serial load/store over the arbitrated 8-bit RAM port. All outputs are
// registered; ex_mem_done pulses for one cycle when the instruction retires.
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global enable, 0 freezes every register
//   bus      : mem_wb_if slave port (execute result, RF/PC write ports, RAM port)
module mem_wb #(
    parameter int unsigned LOG_REG_CNT = 5,
    parameter int unsigned REG_LEN     = 32
) (
    input logic   clk,
    input logic   rst,
    input logic   rdy,
    mem_wb_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StReq, StXfer, StLast, StDone} state_t;

    localparam logic [1:0] OpWb    = 2'd1;
    localparam logic [1:0] OpLoad  = 2'd2;
    localparam logic [1:0] OpStore = 2'd3;

    state_t                 state_q;
    logic [31:0]            addr_q;
    logic [REG_LEN-1:0]     data_q;
    logic [2:0]             type_q;
    logic [LOG_REG_CNT-1:0] rd_q;
    logic                   store_q;
    logic [1:0]             cnt_q;   // byte index k
    logic [1:0]             last_q;  // n - 1
    logic [REG_LEN-1:0]     buf_q;   // load bytes collected so far

    logic [1:0]         last_idx;
    logic [REG_LEN-1:0] load_word;
    logic [REG_LEN-1:0] load_ext;

    always_comb begin
        last_idx = 2'd0;
        case (bus.mem_type)
            3'd2, 3'd7:       last_idx = 2'd3;
            3'd1, 3'd4, 3'd6: last_idx = 2'd1;
            default:          last_idx = 2'd0;
        endcase
    end

    // Final byte arrives on ram_din in the LAST cycle; merge it combinationally so the
    // write-back can be registered on the same edge.
    always_comb begin
        load_word = buf_q;
        load_word[{cnt_q, 3'b000} +: 8] = bus.ram_din;
        case (type_q)
            3'd0:    load_ext = {{(REG_LEN - 8){load_word[7]}}, load_word[7:0]};
            3'd1:    load_ext = {{(REG_LEN - 16){load_word[15]}}, load_word[15:0]};
            3'd3:    load_ext = {{(REG_LEN - 8){1'b0}}, load_word[7:0]};
            3'd4:    load_ext = {{(REG_LEN - 16){1'b0}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            data_q          <= '0;
            type_q          <= '0;
            rd_q            <= '0;
            store_q         <= 1'b0;
            cnt_q           <= '0;
            last_q          <= '0;
            buf_q           <= '0;
            bus.ex_mem_done <= 1'b0;
            bus.rf_we       <= 1'b0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.pc_we       <= 1'b0;
            bus.pc_wdata    <= '0;
            bus.mem_req     <= 1'b0;
            bus.ram_a       <= '0;
            bus.ram_dout    <= '0;
            bus.ram_wr      <= 1'b0;
        end else if (rdy) begin
            // Write ports and the retire pulse are single-cycle
            bus.ex_mem_done <= 1'b0;
            bus.rf_we       <= 1'b0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.pc_we       <= 1'b0;
            bus.pc_wdata    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ex_done) begin
                        if (bus.write_pc) begin
                            bus.pc_we       <= 1'b1;
                            bus.pc_wdata    <= bus.write_pc_val;
                            bus.ex_mem_done <= 1'b1;
                            state_q         <= StDone;
                            if (bus.jmp_rd != '0) begin
                                bus.rf_we    <= 1'b1;
                                bus.rf_waddr <= bus.jmp_rd;
                                bus.rf_wdata <= REG_LEN'(bus.jmp_rd_val);
                            end
                        end else if (bus.write_reg_op == OpLoad ||
                                     bus.write_reg_op == OpStore) begin
                            addr_q      <= bus.mem_addr;
                            data_q      <= bus.write_reg_val;
                            type_q      <= bus.mem_type;
                            rd_q        <= bus.write_reg_id;
                            store_q     <= (bus.write_reg_op == OpStore);
                            last_q      <= last_idx;
                            bus.mem_req <= 1'b1;
                            state_q     <= StReq;
                        end else begin
                            bus.ex_mem_done <= 1'b1;
                            state_q         <= StDone;
                            if (bus.write_reg_op == OpWb && bus.write_reg_id != '0) begin
                                bus.rf_we    <= 1'b1;
                                bus.rf_waddr <= bus.write_reg_id;
                                bus.rf_wdata <= bus.write_reg_val;
                            end
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_gnt) begin
                        state_q      <= StXfer;
                        cnt_q        <= 2'd0;
                        bus.ram_a    <= addr_q;
                        bus.ram_wr   <= store_q;
                        bus.ram_dout <= store_q ? data_q[7:0] : 8'h00;
                    end
                end
                StXfer: begin
                    // ram_din now holds the byte addressed in the previous cycle
                    if (!store_q && cnt_q != 2'd0) begin
                        buf_q[{cnt_q - 2'd1, 3'b000} +: 8] <= bus.ram_din;
                    end
                    if (cnt_q == last_q) begin
                        bus.ram_a    <= '0;
                        bus.ram_wr   <= 1'b0;
                        bus.ram_dout <= '0;
                        if (store_q) begin
                            bus.mem_req     <= 1'b0;
                            bus.ex_mem_done <= 1'b1;
                            state_q         <= StDone;
                        end else begin
                            state_q <= StLast;
                        end
                    end else begin
                        cnt_q        <= cnt_q + 2'd1;
                        bus.ram_a    <= addr_q + {30'd0, cnt_q} + 32'd1;
                        bus.ram_dout <= store_q ? data_q[{cnt_q + 2'd1, 3'b000} +: 8] : 8'h00;
                    end
                end
                StLast: begin
                    bus.mem_req     <= 1'b0;
                    bus.ex_mem_done <= 1'b1;
                    state_q         <= StDone;
                    if (rd_q != '0) begin
                        bus.rf_we    <= 1'b1;
                        bus.rf_waddr <= rd_q;
                        bus.rf_wdata <= load_ext;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed bench for mem_wb. A trace model builds, per instruction, the expected
// output set for every cycle from the stage's timing rules; one compare process checks it each
// cycle. Literal checks pin the model on the documented examples.
module tb_mem_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    mem_wb_if #(.LOG_REG_CNT(5), .REG_LEN(32)) bus ();

    mem_wb #(.LOG_REG_CNT(5), .REG_LEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: arbiter and RAM ----------------
    int rc = 0;
    int gdelay = 0;
    assign bus.mem_gnt = bus.mem_req && (rc >= gdelay);

    always @(posedge clk) begin
        if (rst) rc <= 0;
        else if (rdy) rc <= bus.mem_req ? rc + 1 : 0;
    end

    logic [7:0] ram [0:255];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a = '0;
    logic [7:0] pre_d = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (rdy) begin
            if (bus.mem_req && bus.ram_wr) ram[bus.ram_a[7:0]] <= bus.ram_dout;
            bus.ram_din <= ram[bus.ram_a[7:0]];
        end
    end

    // ---------------- monitors for literal checks ----------------
    int          n_rfwe = 0;
    int          n_done = 0;
    logic [4:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_pc = '0;

    always @(negedge clk) begin
        if (bus.rf_we) begin
            n_rfwe     <= n_rfwe + 1;
            last_waddr <= bus.rf_waddr;
            last_wdata <= bus.rf_wdata;
        end
        if (bus.ex_mem_done) n_done <= n_done + 1;
        if (bus.pc_we) last_pc <= bus.pc_wdata;
    end

    // ---------------- trace model ----------------
    typedef struct packed {
        logic        zero;     // every output must be 0
        logic        done;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        pc_we;
        logic [31:0] pc_wdata;
        logic        req;
        logic        a_care;
        logic [31:0] ram_a;
        logic        w_care;
        logic        wr;
        logic        d_care;
        logic [7:0]  dout;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mdl [0:255];

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t idle();
        exp_t e;
        e = '0;
        e.zero = 1'b1;
        return e;
    endfunction

    exp_t ce;
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            ce = expq.pop_front();
            chk("ex_mem_done", 32'(bus.ex_mem_done), 32'(ce.done));
            chk("rf_we", 32'(bus.rf_we), 32'(ce.rf_we));
            chk("pc_we", 32'(bus.pc_we), 32'(ce.pc_we));
            chk("mem_req", 32'(bus.mem_req), 32'(ce.req));
            if (ce.zero) begin
                chk("idle_rf_waddr", 32'(bus.rf_waddr), 32'd0);
                chk("idle_rf_wdata", bus.rf_wdata, 32'd0);
                chk("idle_pc_wdata", bus.pc_wdata, 32'd0);
                chk("idle_ram_a", bus.ram_a, 32'd0);
                chk("idle_ram_wr", 32'(bus.ram_wr), 32'd0);
                chk("idle_ram_dout", 32'(bus.ram_dout), 32'd0);
            end else begin
                if (ce.rf_we) begin
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(ce.waddr));
                    chk("rf_wdata", bus.rf_wdata, ce.wdata);
                end
                if (ce.pc_we) chk("pc_wdata", bus.pc_wdata, ce.pc_wdata);
                if (ce.a_care) chk("ram_a", bus.ram_a, ce.ram_a);
                if (ce.w_care) chk("ram_wr", 32'(bus.ram_wr), 32'(ce.wr));
                if (ce.d_care) chk("ram_dout", 32'(bus.ram_dout), 32'(ce.dout));
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < 4; k++) begin
            pre_a  = 8'(addr + 32'(k));
            pre_d  = b[k];
            pre_we = 1'b1;
            mdl[8'(addr + 32'(k))] = b[k];
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
    endtask

    // Issue one execute result at C0 and walk it to retirement. frz_at/frz_len pull rdy low
    // for frz_len cycles starting at trace index frz_at; rst_at >= 0 asserts rst in that cycle.
    task automatic run_op(input logic wpc, input logic [31:0] pcv, input logic [4:0] jrd,
                          input logic [31:0] jrv, input logic [1:0] op, input logic [4:0] rd,
                          input logic [31:0] val, input logic [31:0] addr, input logic [2:0] mt,
                          input int gd, input int frz_at, input int frz_len, input int rst_at);
        exp_t        tr[$];
        exp_t        e;
        int          n;
        int          last;
        logic        st;
        logic [31:0] ld;
        tr.push_back(idle());
        if (wpc) begin
            e = blank(); e.done = 1'b1; e.pc_we = 1'b1; e.pc_wdata = pcv;
            e.rf_we = (jrd != 5'd0); e.waddr = jrd; e.wdata = jrv;
            tr.push_back(e);
        end else if (op < 2'd2) begin
            e = blank(); e.done = 1'b1;
            e.rf_we = (op == 2'd1) && (rd != 5'd0); e.waddr = rd; e.wdata = val;
            tr.push_back(e);
        end else begin
            st = (op == 2'd3);
            n  = (mt == 3'd2 || mt == 3'd7) ? 4 : (mt == 3'd1 || mt == 3'd4 || mt == 3'd6) ? 2 : 1;
            for (int i = 0; i <= gd; i++) begin
                e = blank(); e.req = 1'b1; tr.push_back(e);
            end
            for (int k = 0; k < n; k++) begin
                e = blank(); e.req = 1'b1;
                e.a_care = 1'b1; e.ram_a = addr + 32'(k);
                e.w_care = 1'b1; e.wr = st;
                e.d_care = st; e.dout = val[8*k +: 8];
                tr.push_back(e);
                if (st) mdl[8'(addr + 32'(k))] = val[8*k +: 8];
            end
            e = blank();
            if (!st) begin
                e.req = 1'b1; e.w_care = 1'b1; e.wr = 1'b0;
                tr.push_back(e);
                ld = 0;
                for (int k = 0; k < n; k++) ld = ld | (32'(mdl[8'(addr + 32'(k))]) << (8 * k));
                if (mt == 3'd0 && ld[7])  ld = ld | 32'hFFFF_FF00;
                if (mt == 3'd1 && ld[15]) ld = ld | 32'hFFFF_0000;
                e = blank(); e.rf_we = (rd != 5'd0); e.waddr = rd; e.wdata = ld;
            end
            e.done = 1'b1;
            tr.push_back(e);
        end
        for (int i = 0; i < frz_len; i++) tr.insert(frz_at + 1, tr[frz_at]);
        if (rst_at >= 0) begin
            while (tr.size() > rst_at + 1) void'(tr.pop_back());
        end
        last = tr.size() - 1;
        for (int i = 0; i < tr.size(); i++) expq.push_back(tr[i]);
        gdelay            = gd;
        bus.ex_done       = 1'b1;
        bus.write_pc      = wpc;
        bus.write_pc_val  = pcv;
        bus.jmp_rd        = jrd;
        bus.jmp_rd_val    = jrv;
        bus.write_reg_op  = op;
        bus.write_reg_id  = rd;
        bus.write_reg_val = val;
        bus.mem_addr      = addr;
        bus.mem_type      = mt;
        for (int i = 0; i <= last; i++) begin
            rdy = !(frz_len > 0 && i >= frz_at && i < frz_at + frz_len);
            rst = (i == rst_at);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        rdy = 1'b1;
        bus.ex_done = 1'b0;
        bus.write_pc = 1'b0;
        bus.write_reg_op = 2'd0;
    endtask

    int saved_we;
    int saved_done;

    initial begin
        bus.ex_done = 1'b0; bus.write_pc = 1'b0; bus.write_pc_val = '0; bus.jmp_rd = '0;
        bus.jmp_rd_val = '0; bus.write_reg_op = '0; bus.write_reg_id = '0;
        bus.write_reg_val = '0; bus.mem_addr = '0; bus.mem_type = '0;
        bus.ram_din = '0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset state
        chk("rst_ex_mem_done", 32'(bus.ex_mem_done), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk("rst_ram_a", bus.ram_a, 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_pc_wdata", bus.pc_wdata, 32'd0);

        // ADDI x5 = 0x2A
        run_op(0, 0, 0, 0, 2'd1, 5'd5, 32'h2A, 0, 0, 0, 0, 0, -1);
        chk("addi_waddr", 32'(last_waddr), 32'd5);
        chk("addi_wdata", last_wdata, 32'h2A);

        // JAL with link, then without
        run_op(1, 32'h1000, 5'd1, 32'h104, 2'd1, 5'd9, 32'h55, 0, 0, 0, 0, 0, -1);
        chk("jal_pc", last_pc, 32'h1000);
        chk("jal_link_reg", 32'(last_waddr), 32'd1);
        chk("jal_link_val", last_wdata, 32'h104);
        saved_we = n_rfwe;
        run_op(1, 32'h2000, 5'd0, 32'h108, 2'd1, 5'd9, 32'h55, 0, 0, 0, 0, 0, -1);
        chk("jal_nolink_we", 32'(n_rfwe), 32'(saved_we));
        chk("jal2_pc", last_pc, 32'h2000);

        // LW x7 at 0x100, grant withheld 3 cycles
        preload(32'h100, 8'h78, 8'h56, 8'h34, 8'h12);
        run_op(0, 0, 0, 0, 2'd2, 5'd7, 0, 32'h100, 3'd2, 3, 0, 0, -1);
        chk("lw_reg", 32'(last_waddr), 32'd7);
        chk("lw_val", last_wdata, 32'h1234_5678);

        // LH / LHU / LB to x0
        preload(32'h200, 8'h00, 8'h80, 8'h7F, 8'hC3);
        run_op(0, 0, 0, 0, 2'd2, 5'd8, 0, 32'h200, 3'd1, 0, 0, 0, -1);
        chk("lh_val", last_wdata, 32'hFFFF_8000);
        run_op(0, 0, 0, 0, 2'd2, 5'd9, 0, 32'h200, 3'd4, 1, 0, 0, -1);
        chk("lhu_val", last_wdata, 32'h0000_8000);
        saved_we = n_rfwe;
        run_op(0, 0, 0, 0, 2'd2, 5'd0, 0, 32'h201, 3'd0, 0, 0, 0, -1);
        chk("lb_x0_we", 32'(n_rfwe), 32'(saved_we));
        run_op(0, 0, 0, 0, 2'd2, 5'd12, 0, 32'h203, 3'd0, 0, 0, 0, -1);
        chk("lb_val", last_wdata, 32'hFFFF_FFC3);

        // SB at 0x3, SH across the top of the address space, then read it back
        run_op(0, 0, 0, 0, 2'd3, 5'd0, 32'hDEAD_BEEF, 32'h3, 3'd5, 0, 0, 0, -1);
        chk("sb_byte", 32'(ram[3]), 32'hEF);
        run_op(0, 0, 0, 0, 2'd3, 5'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd6, 0, 0, 0, -1);
        chk("sh_byte0", 32'(ram[255]), 32'hEF);
        chk("sh_byte1", 32'(ram[0]), 32'hBE);
        run_op(0, 0, 0, 0, 2'd2, 5'd10, 0, 32'hFFFF_FFFF, 3'd4, 0, 0, 0, -1);
        chk("sh_readback", last_wdata, 32'h0000_BEEF);

        // SW then LW with rdy pulled low mid-transfer
        run_op(0, 0, 0, 0, 2'd3, 5'd0, 32'h4433_2211, 32'h40, 3'd7, 1, 4, 2, -1);
        run_op(0, 0, 0, 0, 2'd2, 5'd11, 0, 32'h40, 3'd2, 0, 3, 3, -1);
        chk("frz_lw_val", last_wdata, 32'h4433_2211);

        // Reset during the XFER of a LW
        saved_we   = n_rfwe;
        saved_done = n_done;
        run_op(0, 0, 0, 0, 2'd2, 5'd13, 0, 32'h100, 3'd2, 0, 0, 0, 3);
        run_op(0, 0, 0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, -1);
        chk("rst_xfer_no_we", 32'(n_rfwe), 32'(saved_we));
        chk("rst_xfer_one_done", 32'(n_done), 32'(saved_done + 1));

        // Recovery after reset
        run_op(0, 0, 0, 0, 2'd1, 5'd31, 32'hCAFE_F00D, 0, 0, 0, 0, 0, -1);
        chk("recover_val", last_wdata, 32'hCAFE_F00D);

        expq.push_back(idle());
        @(posedge clk);
        #1;
        chk("trace_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
